gcd_sched: RTL and testbench

Round-robin scheduler that shares one subtractive GCD engine among `NReq` requesters. It accepts an operand pair from one requester at a time and drives the engine's load/start protocol. It waits for the engine's ready flag, bounded by a timeout, and returns the result tagged with the requester index. It sits between client blocks and the single GCD datapath instance.

---
 rtl/gcd_pkg.sv | 13 +
 rtl/gcd_rr_picker.sv | 31 +++
 rtl/gcd_sched.sv | 120 ++++++++++++
 tb/tb_gcd_sched.sv | 410 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gcd_pkg.sv
// Shared types and defaults for the GCD scheduler slice.
package gcd_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        RUN,
        RESP
    } sched_state_t;

    localparam int unsigned GCD_DEF_TIMEOUT = 1024;

endpackage

// File: rtl/gcd_rr_picker.sv
// Combinational round-robin picker: first valid request after `last`, wrapping.
module gcd_rr_picker #(
    parameter int unsigned NReq = 4
) (
    input  logic [NReq-1:0]         req,
    input  logic [$clog2(NReq)-1:0] last,
    output logic [NReq-1:0]         grant,
    output logic [$clog2(NReq)-1:0] idx
);

    localparam int unsigned IdxW = $clog2(NReq);

    always_comb begin
        logic            found;
        logic [IdxW-1:0] cand;
        grant = '0;
        idx   = '0;
        found = 1'b0;
        cand  = '0;
        // k = 1 checks the requester right after the last winner first
        for (int unsigned k = 1; k <= NReq; k++) begin
            cand = IdxW'((32'(last) + k) % NReq);
            if (!found && req[cand]) begin
                grant[cand] = 1'b1;
                idx         = cand;
                found       = 1'b1;
            end
        end
    end

endmodule

// File: rtl/gcd_sched.sv
// Round-robin scheduler sharing one GCD engine between NReq requesters,
// driving the engine load/start protocol and returning tagged results.
module gcd_sched
    import gcd_pkg::*;
#(
    parameter int unsigned NBits         = 8,
    parameter int unsigned NReq          = 4,
    parameter int unsigned TimeoutCycles = GCD_DEF_TIMEOUT
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NReq-1:0]         req_valid,
    input  logic [NReq*NBits-1:0]   req_x,
    input  logic [NReq*NBits-1:0]   req_y,
    output logic [NReq-1:0]         req_ready,
    output logic                    rsp_valid,
    output logic [$clog2(NReq)-1:0] rsp_id,
    output logic [NBits-1:0]        rsp_data,
    output logic                    rsp_err,
    output logic                    gcd_rst,
    output logic                    gcd_start,
    output logic [NBits-1:0]        gcd_x,
    output logic [NBits-1:0]        gcd_y,
    input  logic [NBits-1:0]        gcd_xo,
    input  logic                    gcd_rdy
);

    localparam int unsigned IdxW = $clog2(NReq);
    localparam int unsigned TW   = $clog2(TimeoutCycles) + 1;

    sched_state_t    state_q, state_d;
    logic [NReq-1:0] grant;
    logic [IdxW-1:0] pick_idx;
    logic [IdxW-1:0] last_q, cur_id_q, rsp_id_q;
    logic [TW-1:0]   tmo_cnt_q;
    logic [NBits-1:0] gcd_x_q, gcd_y_q, rsp_data_q;
    logic            rsp_err_q;
    logic            xfer;
    logic            tmo_hit;

    gcd_rr_picker #(
        .NReq(NReq)
    ) u_picker (
        .req  (req_valid),
        .last (last_q),
        .grant(grant),
        .idx  (pick_idx)
    );

    assign xfer    = (state_q == IDLE) && !rst && (|grant);
    assign tmo_hit = (tmo_cnt_q == TW'(TimeoutCycles - 1));

    always_comb begin
        state_d   = state_q;
        req_ready = '0;
        gcd_start = 1'b0;
        rsp_valid = 1'b0;
        unique case (state_q)
            IDLE: begin
                // Masked during reset so no transfer is claimed that the FSM drops
                req_ready = rst ? '0 : grant;
                if (|grant) state_d = LOAD;
            end
            LOAD: state_d = RUN;
            RUN: begin
                gcd_start = 1'b1;
                if (gcd_rdy || tmo_hit) state_d = RESP;
            end
            RESP: begin
                rsp_valid = 1'b1;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            last_q     <= IdxW'(NReq - 1);
            cur_id_q   <= '0;
            rsp_id_q   <= '0;
            rsp_data_q <= '0;
            rsp_err_q  <= 1'b0;
            tmo_cnt_q  <= '0;
            gcd_x_q    <= '0;
            gcd_y_q    <= '0;
        end else begin
            state_q <= state_d;
            if (xfer) begin
                gcd_x_q  <= req_x[pick_idx*NBits +: NBits];
                gcd_y_q  <= req_y[pick_idx*NBits +: NBits];
                cur_id_q <= pick_idx;
                last_q   <= pick_idx;
            end
            if (state_q == LOAD) tmo_cnt_q <= '0;
            if (state_q == RUN) begin
                tmo_cnt_q <= tmo_cnt_q + TW'(1);
                // Engine completion wins over a timeout in the same cycle
                if (gcd_rdy) begin
                    rsp_data_q <= gcd_xo;
                    rsp_err_q  <= 1'b0;
                    rsp_id_q   <= cur_id_q;
                end else if (tmo_hit) begin
                    rsp_data_q <= '0;
                    rsp_err_q  <= 1'b1;
                    rsp_id_q   <= cur_id_q;
                end
            end
        end
    end

    assign rsp_id   = rsp_id_q;
    assign rsp_data = rsp_data_q;
    assign rsp_err  = rsp_err_q;
    assign gcd_rst  = rst;
    assign gcd_x    = gcd_x_q;
    assign gcd_y    = gcd_y_q;

endmodule

// File: tb/tb_gcd_sched.sv
// Self-checking bench for gcd_sched with a latency-programmable behavioural GCD engine.
module tb_gcd_sched;

    localparam int NR  = 4;
    localparam int NB  = 8;
    localparam int TMO = 8;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [NR-1:0]   req_valid = '0;
    logic [NR*NB-1:0] req_x = '0;
    logic [NR*NB-1:0] req_y = '0;
    logic [NR-1:0]   req_ready;
    logic            rsp_valid;
    logic [1:0]      rsp_id;
    logic [NB-1:0]   rsp_data;
    logic            rsp_err;
    logic            gcd_rst;
    logic            gcd_start;
    logic [NB-1:0]   gcd_x, gcd_y;
    logic [NB-1:0]   gcd_xo;
    logic            gcd_rdy;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    gcd_sched #(
        .NBits(NB),
        .NReq(NR),
        .TimeoutCycles(TMO)
    ) dut (
        .clk(clk),
        .rst(rst),
        .req_valid(req_valid),
        .req_x(req_x),
        .req_y(req_y),
        .req_ready(req_ready),
        .rsp_valid(rsp_valid),
        .rsp_id(rsp_id),
        .rsp_data(rsp_data),
        .rsp_err(rsp_err),
        .gcd_rst(gcd_rst),
        .gcd_start(gcd_start),
        .gcd_x(gcd_x),
        .gcd_y(gcd_y),
        .gcd_xo(gcd_xo),
        .gcd_rdy(gcd_rdy)
    );

    function automatic logic [NB-1:0] gcd_ref(input logic [NB-1:0] a_in, input logic [NB-1:0] b_in);
        logic [NB-1:0] a, b, t;
        a = a_in;
        b = b_in;
        while (b != 0) begin
            t = a % b;
            a = b;
            b = t;
        end
        return a;
    endfunction

    // Engine: loads while start is low; with start high it reports the GCD
    // after eng_lat+1 compute cycles (eng_lat >= 255 means never).
    int            eng_lat = 0;
    int            eng_cnt = 0;
    logic          eng_rdy = 1'b0;
    logic [NB-1:0] eng_xo = '0;
    always @(posedge clk) begin
        if (gcd_rst) begin
            eng_rdy <= 1'b0;
            eng_cnt <= 0;
            eng_xo  <= '0;
        end else if (!gcd_start) begin
            eng_rdy <= 1'b0;
            eng_cnt <= 0;
        end else if (!eng_rdy) begin
            if (eng_cnt == eng_lat) begin
                eng_rdy <= 1'b1;
                eng_xo  <= gcd_ref(gcd_x, gcd_y);
            end
            eng_cnt <= eng_cnt + 1;
        end
    end
    assign gcd_rdy = eng_rdy;
    assign gcd_xo  = eng_xo;

    function automatic int pick_model(input logic [NR-1:0] v, input int last);
        for (int k = 1; k <= NR; k++) if (v[(last + k) % NR]) return (last + k) % NR;
        return -1;
    endfunction

    function automatic int oh2idx(input logic [NR-1:0] v);
        for (int i = 0; i < NR; i++) if (v[i]) return i;
        return -1;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [NB-1:0] x, input logic [NB-1:0] y,
                           input logic v);
        req_x[i*NB +: NB] = x;
        req_y[i*NB +: NB] = y;
        req_valid[i]      = v;
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
    endtask

    // Issue one request and wait for its response; no checking here.
    task automatic one_job(input int r, input logic [NB-1:0] x, input logic [NB-1:0] y,
                           input int lat, output int dt, output logic got,
                           output logic [1:0] id, output logic [NB-1:0] data, output logic err);
        int t0;
        got = 1'b0; dt = -1; id = '0; data = '0; err = 1'b0; t0 = -1;
        set_req(r, x, y, 1'b1);
        for (int k = 0; k < 20 && t0 < 0; k++) begin
            #1;
            if (req_ready[r]) begin
                t0      = cyc;
                eng_lat = lat;
            end
            tick();
        end
        req_valid[r] = 1'b0;
        if (t0 >= 0) begin
            for (int k = 0; k < 30 && !got; k++) begin
                #1;
                if (rsp_valid) begin
                    got = 1'b1; dt = cyc - t0; id = rsp_id; data = rsp_data; err = rsp_err;
                end
                tick();
            end
        end
    endtask

    // Run with the current request inputs, recording grants and responses.
    task automatic run_until(input int want, output int ng, output int nr, output int g[8],
                             output int rid[8], output logic [NB-1:0] rd[8], output logic re[8]);
        logic [NR-1:0] gr;
        ng = 0; nr = 0;
        for (int i = 0; i < 8; i++) begin
            g[i] = -1; rid[i] = -1; rd[i] = '0; re[i] = 1'b0;
        end
        for (int c = 0; c < 200 && nr < want; c++) begin
            #1;
            gr = req_valid & req_ready;
            if (|gr && ng < 8) begin
                g[ng] = oh2idx(gr);
                ng++;
                eng_lat = $urandom_range(0, 4);
            end
            if (rsp_valid && nr < 8) begin
                rid[nr] = int'(rsp_id); rd[nr] = rsp_data; re[nr] = rsp_err;
                nr++;
            end
            tick();
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req_valid = '1;
        req_x = $urandom;
        req_y = $urandom;
        repeat (2) tick();
        #1;
        n_cmp++; if (req_ready !== '0) begin n_bad++; $display("FAIL reset_req_ready: got %b want 0000", req_ready); end
        n_cmp++; if (rsp_valid !== 1'b0) begin n_bad++; $display("FAIL reset_rsp_valid: got %b want 0", rsp_valid); end
        n_cmp++; if (rsp_id !== 2'd0) begin n_bad++; $display("FAIL reset_rsp_id: got %0d want 0", rsp_id); end
        n_cmp++; if (rsp_data !== 8'd0) begin n_bad++; $display("FAIL reset_rsp_data: got %0d want 0", rsp_data); end
        n_cmp++; if (rsp_err !== 1'b0) begin n_bad++; $display("FAIL reset_rsp_err: got %b want 0", rsp_err); end
        n_cmp++; if (gcd_start !== 1'b0) begin n_bad++; $display("FAIL reset_gcd_start: got %b want 0", gcd_start); end
        n_cmp++; if (gcd_x !== 8'd0 || gcd_y !== 8'd0) begin n_bad++; $display("FAIL reset_gcd_xy: got %0d,%0d want 0,0", gcd_x, gcd_y); end
        n_cmp++; if (gcd_rst !== 1'b1) begin n_bad++; $display("FAIL reset_gcd_rst: got %b want 1", gcd_rst); end
        req_valid = '0;
    endtask

    task automatic test_single();
        int lat;
        logic early;
        apply_reset();
        lat = $urandom_range(0, 3);
        eng_lat = lat;
        set_req(0, 8'd12, 8'd18, 1'b1);
        #1;
        n_cmp++; if (req_ready !== 4'b0001) begin n_bad++; $display("FAIL single_grant: got %b want 0001", req_ready); end
        n_cmp++; if (gcd_start !== 1'b0 || gcd_rst !== 1'b0) begin n_bad++; $display("FAIL single_start_T: got start=%b rst=%b want 0,0", gcd_start, gcd_rst); end
        tick();
        req_valid[0] = 1'b0;
        #1;
        n_cmp++; if (gcd_start !== 1'b0) begin n_bad++; $display("FAIL single_start_load: got %b want 0", gcd_start); end
        n_cmp++; if (gcd_x !== 8'd12 || gcd_y !== 8'd18) begin n_bad++; $display("FAIL single_operands: got %0d,%0d want 12,18", gcd_x, gcd_y); end
        tick();
        #1;
        n_cmp++; if (gcd_start !== 1'b1) begin n_bad++; $display("FAIL single_start_run: got %b want 1", gcd_start); end
        // RUN lasts lat+2 cycles; the last one is where the engine flag is first seen
        early = 1'b0;
        for (int k = 0; k < lat + 2; k++) begin
            if (rsp_valid) early = 1'b1;
            if (k == lat + 1 && gcd_start !== 1'b1) early = 1'b1;
            tick();
            #1;
        end
        n_cmp++; if (early) begin n_bad++; $display("FAIL single_run_phase: got early rsp or start drop want none (lat %0d)", lat); end
        n_cmp++; if (rsp_valid !== 1'b1) begin n_bad++; $display("FAIL single_rsp_valid: got %b want 1", rsp_valid); end
        n_cmp++; if (rsp_id !== 2'd0 || rsp_data !== 8'd6 || rsp_err !== 1'b0) begin n_bad++; $display("FAIL single_rsp: got id=%0d data=%0d err=%b want 0,6,0", rsp_id, rsp_data, rsp_err); end
        n_cmp++; if (gcd_start !== 1'b0) begin n_bad++; $display("FAIL single_start_resp: got %b want 0", gcd_start); end
        tick();
        #1;
        n_cmp++; if (rsp_valid !== 1'b0 || rsp_data !== 8'd6) begin n_bad++; $display("FAIL single_hold: got valid=%b data=%0d want 0,6", rsp_valid, rsp_data); end
        tick();
    endtask

    task automatic test_round_robin();
        int ng, nr;
        int g[8], rid[8];
        logic [NB-1:0] rd[8];
        logic re[8];
        int exp_g[5];
        logic [NB-1:0] exp_d[5];
        exp_g = '{0, 1, 2, 3, 0};
        exp_d = '{8'd2, 8'd3, 8'd5, 8'd7, 8'd2};
        apply_reset();
        set_req(0, 8'd4, 8'd6, 1'b1);
        set_req(1, 8'd9, 8'd3, 1'b1);
        set_req(2, 8'd10, 8'd15, 1'b1);
        set_req(3, 8'd7, 8'd7, 1'b1);
        run_until(5, ng, nr, g, rid, rd, re);
        req_valid = '0;
        n_cmp++; if (nr != 5) begin n_bad++; $display("FAIL rr_count: got %0d responses want 5", nr); end
        for (int i = 0; i < 5; i++) begin
            n_cmp++; if (g[i] != exp_g[i]) begin n_bad++; $display("FAIL rr_grant[%0d]: got %0d want %0d", i, g[i], exp_g[i]); end
            n_cmp++; if (rid[i] != exp_g[i] || rd[i] !== exp_d[i] || re[i] !== 1'b0) begin n_bad++; $display("FAIL rr_rsp[%0d]: got id=%0d data=%0d err=%b want %0d,%0d,0", i, rid[i], rd[i], re[i], exp_g[i], exp_d[i]); end
        end
    endtask

    task automatic test_alternate();
        int ng, nr;
        int g[8], rid[8];
        logic [NB-1:0] rd[8];
        logic re[8];
        int exp_g[4];
        exp_g = '{1, 2, 1, 2};
        rst = 1'b1;
        set_req(1, 8'd8, 8'd12, 1'b1);
        set_req(2, 8'd21, 8'd35, 1'b1);
        tick();
        #1;
        n_cmp++; if (req_ready !== '0) begin n_bad++; $display("FAIL alt_ready_in_reset: got %b want 0000", req_ready); end
        tick();
        rst = 1'b0;
        run_until(4, ng, nr, g, rid, rd, re);
        req_valid = '0;
        n_cmp++; if (nr != 4) begin n_bad++; $display("FAIL alt_count: got %0d responses want 4", nr); end
        for (int i = 0; i < 4; i++) begin
            n_cmp++; if (g[i] != exp_g[i]) begin n_bad++; $display("FAIL alt_grant[%0d]: got %0d want %0d", i, g[i], exp_g[i]); end
            n_cmp++; if (rid[i] != exp_g[i] || rd[i] !== ((exp_g[i] == 1) ? 8'd4 : 8'd7)) begin n_bad++; $display("FAIL alt_rsp[%0d]: got id=%0d data=%0d want id %0d", i, rid[i], rd[i], exp_g[i]); end
        end
    endtask

    task automatic test_timeout();
        int dt;
        logic got, err;
        logic [1:0] id;
        logic [NB-1:0] data;
        apply_reset();
        one_job(0, 8'd20, 8'd8, 255, dt, got, id, data, err);
        n_cmp++; if (!got || dt != 2 + TMO) begin n_bad++; $display("FAIL tmo_latency: got got=%b dt=%0d want 1,%0d", got, dt, 2 + TMO); end
        n_cmp++; if (err !== 1'b1 || data !== 8'd0 || id !== 2'd0) begin n_bad++; $display("FAIL tmo_rsp: got err=%b data=%0d id=%0d want 1,0,0", err, data, id); end
        one_job(1, 8'd21, 8'd14, 2, dt, got, id, data, err);
        n_cmp++; if (!got || dt != 6) begin n_bad++; $display("FAIL tmo_next_latency: got got=%b dt=%0d want 1,6", got, dt); end
        n_cmp++; if (err !== 1'b0 || data !== 8'd7 || id !== 2'd1) begin n_bad++; $display("FAIL tmo_next_rsp: got err=%b data=%0d id=%0d want 0,7,1", err, data, id); end
    endtask

    task automatic test_coincide();
        int dt;
        logic got, err;
        logic [1:0] id;
        logic [NB-1:0] data;
        apply_reset();
        // Engine flag first seen in the final RUN cycle
        one_job(2, 8'd45, 8'd27, TMO - 2, dt, got, id, data, err);
        n_cmp++; if (!got || dt != 2 + TMO) begin n_bad++; $display("FAIL coin_latency: got got=%b dt=%0d want 1,%0d", got, dt, 2 + TMO); end
        n_cmp++; if (err !== 1'b0 || data !== 8'd9 || id !== 2'd2) begin n_bad++; $display("FAIL coin_rsp: got err=%b data=%0d id=%0d want 0,9,2", err, data, id); end
    endtask

    task automatic test_reset_mid_run();
        int ng, nr;
        int g[8], rid[8];
        logic [NB-1:0] rd[8];
        logic re[8];
        logic seen;
        apply_reset();
        eng_lat = 255;
        set_req(0, 8'd100, 8'd75, 1'b1);
        seen = 1'b0;
        for (int k = 0; k < 10 && !seen; k++) begin
            #1;
            seen = req_ready[0];
            tick();
        end
        req_valid[0] = 1'b0;
        set_req(3, 8'd30, 8'd42, 1'b1);
        seen = 1'b0;
        for (int k = 0; k < 10 && !seen; k++) begin
            #1;
            seen = gcd_start;
            if (!seen) tick();
        end
        n_cmp++; if (!seen) begin n_bad++; $display("FAIL mid_reach_run: got start=0 want 1"); end
        rst = 1'b1;
        set_req(0, 8'd16, 8'd40, 1'b1);
        tick();
        #1;
        n_cmp++; if (rsp_valid !== 1'b0 || gcd_start !== 1'b0 || req_ready !== '0) begin n_bad++; $display("FAIL mid_ctrl: got valid=%b start=%b ready=%b want 0,0,0000", rsp_valid, gcd_start, req_ready); end
        n_cmp++; if (gcd_x !== 8'd0 || gcd_y !== 8'd0 || rsp_data !== 8'd0 || rsp_id !== 2'd0 || rsp_err !== 1'b0) begin n_bad++; $display("FAIL mid_regs: got x=%0d y=%0d data=%0d id=%0d err=%b want zeros", gcd_x, gcd_y, rsp_data, rsp_id, rsp_err); end
        n_cmp++; if (gcd_rst !== 1'b1) begin n_bad++; $display("FAIL mid_gcd_rst: got %b want 1", gcd_rst); end
        tick();
        rst = 1'b0;
        run_until(2, ng, nr, g, rid, rd, re);
        req_valid = '0;
        n_cmp++; if (nr != 2 || g[0] != 0 || g[1] != 3) begin n_bad++; $display("FAIL mid_order: got n=%0d grants %0d,%0d want 2 grants 0,3", nr, g[0], g[1]); end
        n_cmp++; if (rid[0] != 0 || rd[0] !== 8'd8 || rid[1] != 3 || rd[1] !== 8'd6) begin n_bad++; $display("FAIL mid_rsp: got %0d:%0d %0d:%0d want 0:8 3:6", rid[0], rd[0], rid[1], rd[1]); end
    endtask

    task automatic test_random();
        int tb_last, p, idx, lat, eid;
        logic busy, eerr;
        logic [NR-1:0] exp_g, gr;
        logic [NB-1:0] edata;
        int q_id[$];
        logic [NB-1:0] q_data[$];
        logic q_err[$];
        apply_reset();
        tb_last = NR - 1;
        busy = 1'b0;
        idx = 0;
        for (int c = 0; c < 500; c++) begin
            for (int i = 0; i < NR; i++) begin
                if (c < 470 && !req_valid[i] && $urandom_range(0, 2) == 0)
                    set_req(i, 8'($urandom_range(1, 255)), 8'($urandom_range(1, 255)), 1'b1);
                else if (req_valid[i] && $urandom_range(0, 19) == 0)
                    req_valid[i] = 1'b0;
            end
            #1;
            exp_g = '0;
            if (!busy) begin
                p = pick_model(req_valid, tb_last);
                if (p >= 0) exp_g[p] = 1'b1;
            end
            n_cmp++; if (req_ready !== exp_g) begin n_bad++; $display("FAIL rand_grant@%0d: got %b want %b", cyc, req_ready, exp_g); end
            if (rsp_valid) begin
                n_cmp++;
                if (q_id.size() == 0) begin
                    n_bad++; $display("FAIL rand_spurious_rsp@%0d: got rsp id=%0d want none", cyc, rsp_id);
                end else begin
                    eid = q_id.pop_front(); edata = q_data.pop_front(); eerr = q_err.pop_front();
                    if (int'(rsp_id) != eid || rsp_data !== edata || rsp_err !== eerr) begin
                        n_bad++; $display("FAIL rand_rsp@%0d: got %0d/%0d/%b want %0d/%0d/%b", cyc, rsp_id, rsp_data, rsp_err, eid, edata, eerr);
                    end
                end
                busy = 1'b0;
            end
            gr = req_valid & req_ready;
            if (|gr) begin
                idx = oh2idx(gr);
                lat = $urandom_range(0, 9);
                eng_lat = lat;
                q_id.push_back(idx);
                q_data.push_back((lat >= TMO - 1) ? 8'd0 : gcd_ref(req_x[idx*NB +: NB], req_y[idx*NB +: NB]));
                q_err.push_back(lat >= TMO - 1);
                tb_last = idx;
                busy = 1'b1;
            end
            tick();
            if (|gr) req_valid[idx] = 1'b0;
        end
        n_cmp++; if (q_id.size() != 0 || busy) begin n_bad++; $display("FAIL rand_drain: got %0d pending want 0", q_id.size()); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish want finish before time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_alternate();
        test_timeout();
        test_coincide();
        test_reset_mid_run();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
